// File: rtl/logic_arb_pkg.sv
// Shared types and constants for the two-requester logic-unit arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package logic_arb_pkg;

    // Transaction FSM encoding
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        RESP  = 2'b10
    } state_t;

    // Opcodes passed unmodified to the shared logic unit
    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_NOTA = 2'b10;
    localparam logic [1:0] OP_NAND = 2'b11;

endpackage

// File: rtl/rr_arb2.sv
// Two-way pointer-based grant selection; the pointer breaks ties only.
// Latency: purely combinational.
// Backpressure: none; the caller qualifies the grant with its own state.
module rr_arb2 (
    input  logic i_vld0,
    input  logic i_vld1,
    input  logic i_ptr,
    output logic o_gnt
);

    // A lone requester always wins; on contention the pointer decides
    assign o_gnt = (i_vld0 & i_vld1) ? i_ptr : i_vld1;

endmodule

// File: rtl/logic_unit_arbiter.sv
// Shares one external combinational logic unit between two requesters.
// Latency: accept edge N, operands on lu_* during ISSUE, response after edge N+1.
// Backpressure: one transaction in flight; RESP holds until the granted rsp_ready.
module logic_unit_arbiter
    import logic_arb_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic [1:0]   req0_op,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic [1:0]   req1_op,
    output logic         rsp0_valid,
    input  logic         rsp0_ready,
    output logic [W-1:0] rsp0_data,
    output logic         rsp1_valid,
    input  logic         rsp1_ready,
    output logic [W-1:0] rsp1_data,
    output logic [W-1:0] lu_a,
    output logic [W-1:0] lu_b,
    output logic [1:0]   lu_ctrl,
    input  logic [W-1:0] lu_s,
    output logic         busy
);

    state_t       r_state;
    state_t       w_state_nxt;
    logic         r_ptr;
    logic         r_gnt;
    logic [W-1:0] r_a;
    logic [W-1:0] r_b;
    logic [1:0]   r_op;
    logic [W-1:0] r_res;

    logic         w_gnt;
    logic         w_idle;
    logic         w_accept;
    logic         w_rsp_take;

    rr_arb2 u_rr_arb2 (
        .i_vld0 (req0_valid),
        .i_vld1 (req1_valid),
        .i_ptr  (r_ptr),
        .o_gnt  (w_gnt)
    );

    assign w_idle = (r_state == IDLE);

    // Readies are gated by rst_n so they read 0 while reset is held
    assign req0_ready = rst_n & w_idle & req0_valid & ~w_gnt;
    assign req1_ready = rst_n & w_idle & req1_valid &  w_gnt;
    assign w_accept   = req0_ready | req1_ready;
    assign w_rsp_take = (r_state == RESP) & (r_gnt ? rsp1_ready : rsp0_ready);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: accept -> one issue cycle -> hold response until taken
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept)   w_state_nxt = ISSUE;
            ISSUE:                   w_state_nxt = RESP;
            RESP:    if (w_rsp_take) w_state_nxt = IDLE;
            default:                 w_state_nxt = IDLE;
        endcase
    end

    // Operand capture on accept, result capture at end of ISSUE, pointer flip on completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_op  <= '0;
            r_gnt <= 1'b0;
            r_res <= '0;
            r_ptr <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a   <= w_gnt ? req1_a  : req0_a;
                r_b   <= w_gnt ? req1_b  : req0_b;
                r_op  <= w_gnt ? req1_op : req0_op;
                r_gnt <= w_gnt;
            end
            if (r_state == ISSUE) begin
                r_res <= lu_s;
            end
            if (w_rsp_take) begin
                r_ptr <= ~r_gnt;
            end
        end
    end

    // The logic unit sees the registered operands, which only change on accept
    assign lu_a    = r_a;
    assign lu_b    = r_b;
    assign lu_ctrl = r_op;

    assign rsp0_valid = (r_state == RESP) & ~r_gnt;
    assign rsp1_valid = (r_state == RESP) &  r_gnt;
    assign rsp0_data  = rsp0_valid ? r_res : '0;
    assign rsp1_data  = rsp1_valid ? r_res : '0;

    assign busy = ~w_idle;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
module tb_logic_unit_arbiter;
    import logic_arb_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0]   req0_op, req1_op;
    logic         rsp0_valid, rsp1_valid;
    logic         rsp0_ready, rsp1_ready;
    logic [W-1:0] rsp0_data, rsp1_data;
    logic [W-1:0] lu_a, lu_b, lu_s;
    logic [1:0]   lu_ctrl;
    logic         busy;

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    logic_unit_arbiter #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
        .lu_a(lu_a), .lu_b(lu_b), .lu_ctrl(lu_ctrl), .lu_s(lu_s),
        .busy(busy)
    );

    // External shared logic unit
    always_comb begin
        lu_s = '0;
        case (lu_ctrl)
            OP_AND:  lu_s = lu_a & lu_b;
            OP_OR:   lu_s = lu_a | lu_b;
            OP_NOTA: lu_s = ~lu_a;
            default: lu_s = ~(lu_a & lu_b);
        endcase
    end

    task automatic test_reset();
        rst_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = '0; req0_b = '0; req0_op = '0;
        req1_a = '0; req1_b = '0; req1_op = '0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errs++; $display("FAIL reset_ready: got %b want 00", {req0_ready, req1_ready}); end
        checks++; if ({rsp0_valid, rsp1_valid, busy} !== 3'b000) begin errs++; $display("FAIL reset_valid_busy: got %b want 000", {rsp0_valid, rsp1_valid, busy}); end
        checks++; if ({lu_a, lu_b, lu_ctrl} !== 18'h0) begin errs++; $display("FAIL reset_lu: got %h want 0", {lu_a, lu_b, lu_ctrl}); end
        checks++; if ({rsp0_data, rsp1_data} !== 16'h0) begin errs++; $display("FAIL reset_data: got %h want 0", {rsp0_data, rsp1_data}); end
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        req0_valid = 1'b1; req0_a = 8'hF0; req0_b = 8'h3C; req0_op = 2'b00;
        #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errs++; $display("FAIL single_ready: got %b want 10", {req0_ready, req1_ready}); end
        @(negedge clk);
        req0_valid = 1'b0;
        checks++; if (lu_ctrl !== 2'b00 || lu_a !== 8'hF0 || lu_b !== 8'h3C) begin errs++; $display("FAIL single_issue_lu: got %h/%h/%b want f0/3c/00", lu_a, lu_b, lu_ctrl); end
        checks++; if (busy !== 1'b1 || rsp0_valid !== 1'b0) begin errs++; $display("FAIL single_issue_state: busy=%b rsp0_valid=%b want 1/0", busy, rsp0_valid); end
        @(negedge clk);
        checks++; if (rsp0_valid !== 1'b1 || rsp0_data !== 8'h30) begin errs++; $display("FAIL single_resp: got %b/%h want 1/30", rsp0_valid, rsp0_data); end
        checks++; if (rsp1_valid !== 1'b0 || rsp1_data !== 8'h00) begin errs++; $display("FAIL single_other_rsp: got %b/%h want 0/00", rsp1_valid, rsp1_data); end
        rsp0_ready = 1'b1;
        @(negedge clk);
        rsp0_ready = 1'b0;
        checks++; if ({busy, rsp0_valid, rsp0_data} !== 10'h0) begin errs++; $display("FAIL single_done: got busy=%b v=%b d=%h want 0/0/00", busy, rsp0_valid, rsp0_data); end
    endtask

    task automatic test_stall();
        req0_valid = 1'b1; req0_a = 8'h11; req0_b = 8'h22; req0_op = 2'b01;
        #1;
        checks++; if (req0_ready !== 1'b1) begin errs++; $display("FAIL stall_accept: got %b want 1", req0_ready); end
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 8'h77; req1_b = 8'h88; req1_op = 2'b00;
        #1;
        checks++; if (req1_ready !== 1'b0) begin errs++; $display("FAIL stall_issue_req1: got %b want 0", req1_ready); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (rsp0_valid !== 1'b1 || rsp0_data !== 8'h33 || busy !== 1'b1) begin errs++; $display("FAIL stall_hold[%0d]: got v=%b d=%h busy=%b want 1/33/1", i, rsp0_valid, rsp0_data, busy); end
            checks++; if (req1_ready !== 1'b0 || lu_a !== 8'h11) begin errs++; $display("FAIL stall_block[%0d]: got rdy1=%b lu_a=%h want 0/11", i, req1_ready, lu_a); end
        end
        rsp0_ready = 1'b1; req1_valid = 1'b0;
        @(negedge clk);
        rsp0_ready = 1'b0;
        checks++; if (busy !== 1'b0 || rsp0_valid !== 1'b0) begin errs++; $display("FAIL stall_release: got busy=%b v=%b want 0/0", busy, rsp0_valid); end
    endtask

    task automatic test_both();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 8'h0F; req0_b = 8'hA0; req0_op = 2'b01;
        req1_valid = 1'b1; req1_a = 8'h55; req1_b = 8'h00; req1_op = 2'b10;
        #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errs++; $display("FAIL both_first_grant: got %b want 10", {req0_ready, req1_ready}); end
        @(negedge clk);
        req0_valid = 1'b0;
        checks++; if (lu_ctrl !== 2'b01 || req1_ready !== 1'b0) begin errs++; $display("FAIL both_issue0: got ctrl=%b rdy1=%b want 01/0", lu_ctrl, req1_ready); end
        @(negedge clk);
        checks++; if (rsp0_valid !== 1'b1 || rsp0_data !== 8'hAF || rsp1_valid !== 1'b0) begin errs++; $display("FAIL both_rsp0: got v=%b d=%h v1=%b want 1/af/0", rsp0_valid, rsp0_data, rsp1_valid); end
        @(negedge clk);
        checks++; if ({req0_ready, req1_ready} !== 2'b01) begin errs++; $display("FAIL both_second_grant: got %b want 01", {req0_ready, req1_ready}); end
        @(negedge clk);
        req1_valid = 1'b0;
        checks++; if (lu_ctrl !== 2'b10 || lu_a !== 8'h55) begin errs++; $display("FAIL both_issue1: got ctrl=%b a=%h want 10/55", lu_ctrl, lu_a); end
        @(negedge clk);
        checks++; if (rsp1_valid !== 1'b1 || rsp1_data !== 8'hAA || rsp0_valid !== 1'b0) begin errs++; $display("FAIL both_rsp1: got v=%b d=%h v0=%b want 1/aa/0", rsp1_valid, rsp1_data, rsp0_valid); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL both_idle: got %b want 0", busy); end
    endtask

    task automatic test_nand();
        logic [W-1:0] s_issue;
        req0_valid = 1'b1; req0_a = 8'hFF; req0_b = 8'h0F; req0_op = 2'b11;
        @(negedge clk);
        req0_valid = 1'b0;
        s_issue = lu_s;
        checks++; if (lu_ctrl !== 2'b11) begin errs++; $display("FAIL nand_ctrl: got %b want 11", lu_ctrl); end
        @(negedge clk);
        checks++; if (rsp0_valid !== 1'b1 || rsp0_data !== 8'hF0) begin errs++; $display("FAIL nand_data: got v=%b d=%h want 1/f0", rsp0_valid, rsp0_data); end
        checks++; if (rsp0_data !== s_issue) begin errs++; $display("FAIL nand_lu_s: got %h want %h", rsp0_data, s_issue); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        req1_valid = 1'b1; req1_a = 8'hFF; req1_b = 8'hFF; req1_op = 2'b00;
        #1;
        checks++; if (req1_ready !== 1'b1) begin errs++; $display("FAIL rmid_accept: got %b want 1", req1_ready); end
        @(negedge clk);
        req1_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if ({busy, rsp0_valid, rsp1_valid, req0_ready, req1_ready} !== 5'b0) begin errs++; $display("FAIL rmid_ctrl_out: got %b want 00000", {busy, rsp0_valid, rsp1_valid, req0_ready, req1_ready}); end
        checks++; if ({lu_a, lu_b, lu_ctrl, rsp0_data, rsp1_data} !== 34'h0) begin errs++; $display("FAIL rmid_data_out: got %h want 0", {lu_a, lu_b, lu_ctrl, rsp0_data, rsp1_data}); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if ({rsp0_valid, rsp1_valid, busy} !== 3'b000) begin errs++; $display("FAIL rmid_no_rsp[%0d]: got %b want 000", i, {rsp0_valid, rsp1_valid, busy}); end
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errs++; $display("FAIL rmid_ptr: got %b want 10", {req0_ready, req1_ready}); end
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int g[$];
        int t[$];
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 8'h3C; req0_b = 8'h0F; req0_op = 2'b00;
        req1_valid = 1'b1; req1_a = 8'hC3; req1_b = 8'hF0; req1_op = 2'b01;
        for (int c = 0; c < 20 && g.size() < 4; c++) begin
            #1;
            checks++; if (req0_ready && req1_ready) begin errs++; $display("FAIL b2b_dual_ready[%0d]: got 11 want not both", c); end
            if (req0_ready) begin g.push_back(0); t.push_back(c); end
            else if (req1_ready) begin g.push_back(1); t.push_back(c); end
            @(negedge clk);
        end
        checks++; if (g.size() != 4) begin errs++; $display("FAIL b2b_count: got %0d want 4", g.size()); end
        for (int i = 0; i < g.size(); i++) begin
            checks++; if (g[i] != (i % 2)) begin errs++; $display("FAIL b2b_grant[%0d]: got %0d want %0d", i, g[i], i % 2); end
            if (i > 0) begin
                checks++; if (t[i] - t[i-1] != 3) begin errs++; $display("FAIL b2b_gap[%0d]: got %0d want 3", i, t[i] - t[i-1]); end
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL b2b_drain: got %b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stall();
        test_both();
        test_nand();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/logic_unit_arbiter.md
LOGIC_UNIT_ARBITER -- requirements
Module: logic_unit_arbiter

Interface
REQ-001 Parameter: W, 8, operand/result width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req0_valid / req1_valid  input  1  requester i presents an operation.
REQ-005 req0_ready / req1_ready  output  1  requester i operation accepted this cycle.
REQ-006 req0_a, req0_b / req1_a, req1_b  input  W  operands of requester i.
REQ-007 req0_op / req1_op  input  2  opcode of requester i: 00 and, 01 or, 10 not a, 11 nand.
REQ-008 rsp0_valid / rsp1_valid  output  1  result for requester i available.
REQ-009 rsp0_ready / rsp1_ready  input  1  requester i takes its result.
REQ-010 rsp0_data / rsp1_data  output  W  result for requester i.
REQ-011 lu_a, lu_b  output  W  operands driven to the shared combinational logic unit.
REQ-012 lu_ctrl  output  2  opcode driven to the shared logic unit.
REQ-013 lu_s  input  W  combinational result returned by the shared logic unit.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 The block SHALL implement an FSM with states IDLE, ISSUE and RESP.
REQ-016 In IDLE with exactly one reqi_valid high, the block SHALL grant requester i.
REQ-017 In IDLE with both valid high, the block SHALL grant the requester selected by a 1-bit priority pointer.
REQ-018 reqi_ready SHALL be high only in IDLE, only while reqi_valid is high, and only for the granted requester; both readys SHALL never be high together.
REQ-019 On the accepting edge (valid and ready high), the block SHALL register a, b, op and grant index, then enter ISSUE.
REQ-020 In ISSUE, lu_a, lu_b and lu_ctrl SHALL equal the registered operands and opcode, held stable for the whole cycle.
REQ-021 At the end of ISSUE, the block SHALL capture lu_s into the result register and enter RESP.
REQ-022 In RESP, rsp<g>_valid SHALL be high and rsp<g>_data SHALL equal the captured result, where g is the grant index; the other rsp valid SHALL be low.
REQ-023 rsp_valid and rsp_data SHALL stay stable in RESP until rsp<g>_ready is high on a rising edge; the block SHALL then enter IDLE and set the pointer to ~g.
REQ-024 Latency SHALL be: accepted at edge N, rsp valid from cycle N+2; minimum issue interval is 3 cycles.
REQ-025 All four opcodes SHALL pass to lu_ctrl unmodified; the block SHALL NOT compute or correct the result itself.
REQ-026 Outside ISSUE, lu_a, lu_b and lu_ctrl SHALL hold their last registered values.
REQ-027 If a requester drops valid before the handshake, no operation SHALL be recorded for it.
REQ-028 New request valids SHALL be ignored in ISSUE and RESP.
REQ-029 rspi_data SHALL read 0 whenever rspi_valid is low.

Reset
REQ-030 While rst_n is low, the state SHALL be IDLE and the pointer SHALL be 0 (requester 0 first).
REQ-031 While rst_n is low, the operand, opcode and result registers SHALL be 0, and all ready, rsp valid and busy outputs SHALL be 0.
REQ-032 Reset asserted mid-transaction SHALL discard that transaction; no response SHALL follow reset release.

Structure
REQ-033 Package logic_arb_pkg SHALL hold the state encoding (IDLE 2'b00, ISSUE 2'b01, RESP 2'b10) and the opcode constants OP_AND, OP_OR, OP_NOTA and OP_NAND.
REQ-034 The two-way pointer-based choice SHALL be a sub-module rr_arb2 (inputs: two valids and the pointer; output: the grant index).
REQ-035 The shared logic unit SHALL be instantiated outside this block.

Verification
REQ-036 Scenario: req0 a=8'hF0, b=8'h3C, op=00 only -> ready0 at accept edge N; lu_ctrl=00 in ISSUE; rsp0_valid at N+2 with data=8'h30.
REQ-037 Scenario: both valid after reset, req0 op=01 a=8'h0F b=8'hA0, req1 op=10 a=8'h55 -> req0 served first with 8'hAF, then req1 served with 8'hAA; no simultaneous readys.
REQ-038 Scenario: rsp0_ready held low 5 cycles -> rsp0_valid and data stable for 5 cycles, busy=1 throughout, req1 not accepted.
REQ-039 Scenario: op=11 with a=8'hFF, b=8'h0F -> lu_ctrl=11 in ISSUE and rsp data equals lu_s sampled at end of ISSUE.
REQ-040 Scenario: rst_n pulsed low during ISSUE -> all outputs 0 immediately, no rsp after release, pointer back to requester 0.
REQ-041 Scenario: both valid held continuously for 4 transactions -> grants alternate 0,1,0,1, each 3 cycles apart with rsp_ready tied high.
